// File: rtl/soc_timer_sequencer_master.sv
// rtl/soc_timer_sequencer_master.sv - Avalon-MM master sequencing the interval-timer slave
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cmd_valid/cmd_ready        : command handshake; cmd_count, cmd_use_irq sampled on accept
//   abort                      : abort request (level or pulse)
//   busy, done                 : activity flag, one-cycle completion pulse
//   done_status/count/snapshot : held completion results
//   tmr_*                      : timer slave bus (address, chipselect, write_n, writedata, readdata, irq)
module soc_timer_sequencer_master #(
  parameter int POLL_INTERVAL = 8,
  parameter int WD_CYCLES     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_count,
  input  logic        cmd_use_irq,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [1:0]  done_status,
  output logic [15:0] done_count,
  output logic [15:0] done_snapshot,
  output logic [3:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq
);

  localparam int PI_W = $clog2(POLL_INTERVAL + 1);
  localparam int WD_W = $clog2(WD_CYCLES + 1);
  localparam logic [PI_W-1:0] PI_ONE = 1;
  localparam logic [WD_W-1:0] WD_ONE = 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START_WR, S_WAIT, S_POLL_RD, S_POLL_CAP, S_CLR_WR,
    S_STOP_WR, S_SNAP_WR, S_SNAP_RD, S_SNAP_CAP, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cmd_count_q, cmd_count_d;
  logic              use_irq_q, use_irq_d;
  logic [15:0]       count_q, count_d;
  logic [1:0]        status_q, status_d;
  logic [15:0]       snap_q, snap_d;
  logic              abort_pend_q, abort_pend_d;
  logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
  logic [PI_W-1:0]   poll_q, poll_d;
  logic              done_q, done_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic [3:0]        addr_q, addr_d;
  logic              cs_q, cs_d;
  logic              wn_q, wn_d;
  logic [15:0]       wdata_q, wdata_d;

  always_comb begin
    state_d      = state_q;
    cmd_count_d  = cmd_count_q;
    use_irq_d    = use_irq_q;
    count_d      = count_q;
    status_d     = status_q;
    snap_d       = snap_q;
    wd_d         = wd_q;
    poll_d       = poll_q;
    // Abort is remembered in every busy state but only acted upon in WAIT.
    abort_pend_d = abort_pend_q | (abort && (state_q != S_IDLE));
    // Watchdog saturates at its limit instead of wrapping.
    wd_inc       = (int'(wd_q) >= WD_CYCLES) ? wd_q : wd_q + WD_ONE;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_count_d  = cmd_count;
          use_irq_d    = cmd_use_irq;
          count_d      = 16'd0;
          status_d     = 2'b00;
          snap_d       = 16'd0;
          wd_d         = '0;
          poll_d       = '0;
          abort_pend_d = 1'b0;
          state_d      = (cmd_count == 16'd0) ? S_DONE : S_START_WR;
        end
      end
      S_START_WR: begin
        wd_d    = '0;
        poll_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d   = wd_inc;
        poll_d = (int'(poll_q) >= POLL_INTERVAL) ? poll_q : poll_q + PI_ONE;
        // A limit "reached" means this is the Nth cycle counted, hence the -1.
        if (abort_pend_q) begin
          status_d = 2'b01;
          state_d  = S_STOP_WR;
        end else if (use_irq_q && tmr_irq) begin
          state_d = S_CLR_WR;
        end else if (!use_irq_q && (int'(poll_q) >= POLL_INTERVAL - 1)) begin
          state_d = S_POLL_RD;
        end else if (int'(wd_q) >= WD_CYCLES - 1) begin
          status_d = 2'b10;
          state_d  = S_STOP_WR;
        end
      end
      S_POLL_RD: begin
        wd_d    = wd_inc;
        state_d = S_POLL_CAP;
      end
      S_POLL_CAP: begin
        wd_d = wd_inc;
        if (tmr_readdata[0]) begin
          state_d = S_CLR_WR;
        end else begin
          poll_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_CLR_WR: begin
        wd_d    = '0;
        poll_d  = '0;
        count_d = count_q + 16'd1;
        if (({1'b0, count_q} + 17'd1) == {1'b0, cmd_count_q}) begin
          // Final timeout wins over any abort that arrived alongside it.
          status_d     = 2'b00;
          abort_pend_d = 1'b0;
          state_d      = S_STOP_WR;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_STOP_WR:  state_d = S_SNAP_WR;
      S_SNAP_WR:  state_d = S_SNAP_RD;
      S_SNAP_RD:  state_d = S_SNAP_CAP;
      S_SNAP_CAP: begin
        snap_d  = tmr_readdata;
        state_d = S_DONE;
      end
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    cs_d        = 1'b0;
    wn_d        = 1'b1;
    addr_d      = 4'd0;
    wdata_d     = 16'h0000;
    case (state_d)
      S_START_WR: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd1;
        wdata_d = 16'h0006 | {15'd0, use_irq_d};
      end
      S_POLL_RD, S_POLL_CAP: begin
        cs_d = 1'b1; addr_d = 4'd0;
      end
      S_CLR_WR: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd0;
      end
      S_STOP_WR: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd1; wdata_d = 16'h0008;
      end
      S_SNAP_WR: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd6;
      end
      S_SNAP_RD, S_SNAP_CAP: begin
        cs_d = 1'b1; addr_d = 4'd6;
      end
      default: begin
        cs_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_count_q  <= 16'd0;
      use_irq_q    <= 1'b0;
      count_q      <= 16'd0;
      status_q     <= 2'b00;
      snap_q       <= 16'd0;
      abort_pend_q <= 1'b0;
      wd_q         <= '0;
      poll_q       <= '0;
      done_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      addr_q       <= 4'd0;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      wdata_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cmd_count_q  <= cmd_count_d;
      use_irq_q    <= use_irq_d;
      count_q      <= count_d;
      status_q     <= status_d;
      snap_q       <= snap_d;
      abort_pend_q <= abort_pend_d;
      wd_q         <= wd_d;
      poll_q       <= poll_d;
      done_q       <= done_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      addr_q       <= addr_d;
      cs_q         <= cs_d;
      wn_q         <= wn_d;
      wdata_q      <= wdata_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign done_status    = status_q;
  assign done_count     = count_q;
  assign done_snapshot  = snap_q;
  assign tmr_address    = addr_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wn_q;
  assign tmr_writedata  = wdata_q;

endmodule

// File: tb/tb_soc_timer_sequencer_master.sv
// tb/tb_soc_timer_sequencer_master.sv - bench for soc_timer_sequencer_master with interval-timer model
module tb_soc_timer_sequencer_master;

  localparam int POLL_INTERVAL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cmd_valid, cmd_use_irq, abort;
  logic [15:0] cmd_count;
  logic        cmd_ready, busy, done;
  logic [1:0]  done_status;
  logic [15:0] done_count, done_snapshot;
  logic [3:0]  tmr_address;
  logic        tmr_chipselect, tmr_write_n, tmr_irq;
  logic [15:0] tmr_writedata, tmr_readdata;

  logic        wd_cmd_valid, wd_cmd_use_irq, wd_abort;
  logic [15:0] wd_cmd_count;
  logic        wd_cmd_ready, wd_busy, wd_done;
  logic [1:0]  wd_done_status;
  logic [15:0] wd_done_count, wd_done_snapshot;
  logic [3:0]  wd_tmr_address;
  logic        wd_tmr_chipselect, wd_tmr_write_n, wd_tmr_irq;
  logic [15:0] wd_tmr_writedata, wd_tmr_readdata;

  soc_timer_sequencer_master #(.POLL_INTERVAL(POLL_INTERVAL), .WD_CYCLES(1024)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .cmd_use_irq(cmd_use_irq), .abort(abort), .busy(busy),
    .done(done), .done_status(done_status), .done_count(done_count),
    .done_snapshot(done_snapshot), .tmr_address(tmr_address),
    .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  soc_timer_sequencer_master #(.POLL_INTERVAL(POLL_INTERVAL), .WD_CYCLES(64)) dut_wd (
    .clk(clk), .reset(reset), .cmd_valid(wd_cmd_valid), .cmd_ready(wd_cmd_ready),
    .cmd_count(wd_cmd_count), .cmd_use_irq(wd_cmd_use_irq), .abort(wd_abort), .busy(wd_busy),
    .done(wd_done), .done_status(wd_done_status), .done_count(wd_done_count),
    .done_snapshot(wd_done_snapshot), .tmr_address(wd_tmr_address),
    .tmr_chipselect(wd_tmr_chipselect), .tmr_write_n(wd_tmr_write_n),
    .tmr_writedata(wd_tmr_writedata), .tmr_readdata(wd_tmr_readdata), .tmr_irq(wd_tmr_irq)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Interval timer model: 100-cycle period, registered readdata.
  logic        t_run, t_cont, t_ito, t_to;
  logic [6:0]  t_cnt;
  logic [15:0] t_snap, t_rdata;
  assign tmr_irq      = t_to & t_ito;
  assign tmr_readdata = t_rdata;

  always @(posedge clk) begin
    if (reset) begin
      t_run <= 1'b0; t_cont <= 1'b0; t_ito <= 1'b0; t_to <= 1'b0;
      t_cnt <= 7'd0; t_snap <= 16'd0; t_rdata <= 16'd0;
    end else begin
      if (t_run) begin
        if (t_cnt == 7'd99) begin
          t_cnt <= 7'd0;
          t_to  <= 1'b1;
          if (!t_cont) t_run <= 1'b0;
        end else begin
          t_cnt <= t_cnt + 7'd1;
        end
      end
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          4'd0: t_to <= 1'b0;
          4'd1: begin
            t_ito  <= tmr_writedata[0];
            t_cont <= tmr_writedata[1];
            if (tmr_writedata[2]) begin t_run <= 1'b1; t_cnt <= 7'd0; end
            if (tmr_writedata[3]) t_run <= 1'b0;
          end
          4'd6: t_snap <= {9'd0, t_cnt};
          default: t_snap <= t_snap;
        endcase
      end
      t_rdata <= 16'd0;
      if (tmr_chipselect && tmr_write_n) begin
        if (tmr_address == 4'd0) t_rdata <= {14'd0, t_run, t_to};
        else if (tmr_address == 4'd6) t_rdata <= t_snap;
      end
    end
  end

  // Scoreboards
  typedef struct packed { logic [3:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic [1:0] status; logic [15:0] count; bit snap_zero; } res_t;
  wr_t  wr_q[$];
  res_t res_q[$];

  int  done_seen = 0;
  int  clr_seen = 0;
  int  to_rise_cyc = 0;
  bit  prev_to = 1'b0;
  bit  cur_irq = 1'b0;

  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    int   lat;
    if (!reset) begin
      if (t_to && !prev_to) to_rise_cyc = cyc;
      prev_to = t_to;
      if (tmr_chipselect && !tmr_write_n) begin
        if (wr_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected", tmr_address, tmr_writedata);
        end else begin
          w = wr_q.pop_front();
          chk("bus_write", {12'd0, tmr_address, tmr_writedata}, {12'd0, w.addr, w.data});
        end
        if (tmr_address == 4'd0) begin
          clr_seen++;
          chk("clr_with_to_set", 32'(t_to), 32'd1);
          lat = cyc - to_rise_cyc;
          if (cur_irq) chk("irq_clr_latency", lat, 1);
          else begin
            n_cmp++;
            if (lat < 1 || lat > POLL_INTERVAL + 3) begin
              n_fail++;
              $display("FAIL poll_clr_latency: got %0d cycles, required 1..%0d", lat, POLL_INTERVAL + 3);
            end
          end
        end
      end
      if (done) begin
        done_seen++;
        if (res_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done: status %0d count %0d", done_status, done_count);
        end else begin
          r = res_q.pop_front();
          chk("done_status", 32'(done_status), 32'(r.status));
          chk("done_count", 32'(done_count), 32'(r.count));
          chk("done_snapshot", 32'(done_snapshot), r.snap_zero ? 32'd0 : 32'(t_snap));
          chk("snapshot_le_99", 32'(done_snapshot <= 16'd99), 32'd1);
        end
      end
    end
  end

  int wd_done_seen = 0;
  int wd_start_cyc = 0;
  int wd_stop_cyc = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (wd_tmr_chipselect && !wd_tmr_write_n) begin
        if (wd_tmr_address == 4'd1 && wd_tmr_writedata[2]) wd_start_cyc = cyc;
        else if (wd_tmr_address == 4'd1 && wd_tmr_writedata[3]) wd_stop_cyc = cyc;
        else if (wd_tmr_address == 4'd0) begin
          n_cmp++; n_fail++;
          $display("FAIL wd_unexpected_clear: write to addr 0 with no timeout");
        end
      end
      if (wd_done) wd_done_seen++;
    end
  end

  typedef struct {
    logic [15:0] count;
    logic        use_irq;
    int          abort_after;
    logic [1:0]  exp_status;
    logic [15:0] exp_count;
  } vec_t;
  vec_t vecs[6];

  task automatic wait_done(input int base, input string name);
    int t = 0;
    while (done_seen == base && t < 3000) begin @(negedge clk); t++; end
    if (done_seen == base) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: no done within %0d cycles", name, t);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int t;
    int base_done;
    int base_clr;
    @(negedge clk);
    if (v.count != 16'd0) begin
      wr_q.push_back('{4'd1, 16'h0006 | {15'd0, v.use_irq}});
      for (int i = 0; i < int'(v.exp_count); i++) wr_q.push_back('{4'd0, 16'h0000});
      wr_q.push_back('{4'd1, 16'h0008});
      wr_q.push_back('{4'd6, 16'h0000});
    end
    res_q.push_back('{v.exp_status, v.exp_count, (v.count == 16'd0)});
    cur_irq   = v.use_irq;
    base_done = done_seen;
    base_clr  = clr_seen;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_count = v.count; cmd_use_irq = v.use_irq;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (v.abort_after >= 0) begin
      t = 0;
      while (clr_seen == base_clr && t < 2000) begin @(negedge clk); t++; end
      repeat (v.abort_after) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    wait_done(base_done, "vector_done_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic wd_run(input logic use_irq);
    int t = 0;
    int base = wd_done_seen;
    @(negedge clk);
    wd_cmd_valid = 1'b1; wd_cmd_count = 16'd5; wd_cmd_use_irq = use_irq;
    @(negedge clk);
    wd_cmd_valid = 1'b0;
    while (wd_done_seen == base && t < 500) begin @(negedge clk); t++; end
    if (wd_done_seen == base) begin
      n_cmp++; n_fail++;
      $display("FAIL wd_done_timeout: no done within %0d cycles", t);
    end else begin
      chk("wd_status", 32'(wd_done_status), 32'd2);
      chk("wd_count", 32'(wd_done_count), 32'd0);
      chk("wd_snapshot", 32'(wd_done_snapshot), 32'd0);
      chk("wd_start_to_stop", wd_stop_cyc - wd_start_cyc, 65);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    reset = 1'b1; cmd_valid = 1'b0; cmd_count = 16'd0; cmd_use_irq = 1'b0; abort = 1'b0;
    wd_cmd_valid = 1'b0; wd_cmd_count = 16'd0; wd_cmd_use_irq = 1'b0; wd_abort = 1'b0;
    wd_tmr_readdata = 16'd0; wd_tmr_irq = 1'b0;

    vecs[0] = '{16'd3, 1'b1, -1, 2'b00, 16'd3};
    vecs[1] = '{16'd2, 1'b0, -1, 2'b00, 16'd2};
    vecs[2] = '{16'd3, 1'b1, 40, 2'b01, 16'd1};
    vecs[3] = '{16'd0, 1'b1, -1, 2'b00, 16'd0};
    vecs[4] = '{16'd1, 1'b0, -1, 2'b00, 16'd1};
    vecs[5] = '{16'd2, 1'b0, 40, 2'b01, 16'd1};

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_status", 32'(done_status), 32'd0);
    chk("rst_count", 32'(done_count), 32'd0);
    chk("rst_snapshot", 32'(done_snapshot), 32'd0);
    chk("rst_bus", {13'd0, tmr_address, tmr_chipselect, tmr_write_n, 13'd0},
        {13'd0, 4'd0, 1'b0, 1'b1, 13'd0});
    chk("rst_wdata", 32'(tmr_writedata), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // cmd_count = 0: done exactly one cycle after accept, no bus activity
    @(negedge clk);
    res_q.push_back('{2'b00, 16'd0, 1'b1});
    cmd_valid = 1'b1; cmd_count = 16'd0; cmd_use_irq = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("zero_done_pulse", 32'(done), 32'd1);
    chk("zero_no_cs", 32'(tmr_chipselect), 32'd0);
    @(negedge clk);
    chk("zero_done_low", 32'(done), 32'd0);
    chk("zero_ready_again", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);

    // abort coinciding with the final CLR_WR is discarded
    wr_q.push_back('{4'd1, 16'h0007});
    wr_q.push_back('{4'd0, 16'h0000});
    wr_q.push_back('{4'd1, 16'h0008});
    wr_q.push_back('{4'd6, 16'h0000});
    res_q.push_back('{2'b00, 16'd1, 1'b0});
    cur_irq = 1'b1;
    base = done_seen;
    cmd_valid = 1'b1; cmd_count = 16'd1; cmd_use_irq = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    begin
      int t = 0;
      while (!tmr_irq && t < 300) begin @(negedge clk); t++; end
      if (!tmr_irq) begin
        n_cmp++; n_fail++;
        $display("FAIL late_abort_irq_timeout: irq not seen in %0d cycles", t);
      end
    end
    @(negedge clk);
    abort = 1'b1;
    chk("late_abort_in_clr", {28'd0, tmr_address}, 32'd0);
    chk("late_abort_is_write", 32'(tmr_chipselect && !tmr_write_n), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    wait_done(base, "late_abort_done_timeout");
    repeat (2) @(negedge clk);

    wd_run(1'b0);
    wd_run(1'b1);

    // reset asserted for three cycles in the middle of WAIT
    wr_q.push_back('{4'd1, 16'h0007});
    cur_irq = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_count = 16'd3; cmd_use_irq = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (50) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    base = done_seen;
    reset = 1'b1;
    wr_q.delete();
    res_q.delete();
    @(negedge clk);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cs", 32'(tmr_chipselect), 32'd0);
    chk("mid_rst_status", 32'(done_status), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    repeat (200) @(negedge clk);
    chk("post_rst_no_done", done_seen, base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
